// File: rtl/shift_reg_universal_if.sv
// Bus bundle for shift_reg_universal: control/data inputs and register outputs.
// SHIFT_REG_PARITY_EN adds the parity output to the bundle.
interface shift_reg_universal_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic [CW-1:0]    cnt;
  logic             done;
`ifdef SHIFT_REG_PARITY_EN
  logic             parity;

  modport master (output en, mode, d, sin, input q, sout, cnt, done, parity);
  modport slave  (input en, mode, d, sin, output q, sout, cnt, done, parity);
`else
  modport master (output en, mode, d, sin, input q, sout, cnt, done);
  modport slave  (input en, mode, d, sin, output q, sout, cnt, done);
`endif
endinterface

// File: rtl/shift_reg_universal.sv
// Universal WIDTH-bit register: hold/load/shift/rotate with saturating shift count and done flag.
// Optional macro SHIFT_REG_PARITY_EN drives an even-parity output of q.
module shift_reg_universal #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rst,
  shift_reg_universal_if.slave  bus
);
  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_RSV6  = 3'b110,
    MODE_RSV7  = 3'b111
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             step;

  assign mode = mode_e'(bus.mode);

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    step  = 1'b0;
    unique case (mode)
      MODE_LOAD: begin
        q_d   = bus.d;
        cnt_d = '0;
      end
      MODE_SHL: begin
        q_d  = {q_q[WIDTH-2:0], bus.sin};
        step = 1'b1;
      end
      MODE_SHR: begin
        q_d  = {bus.sin, q_q[WIDTH-1:1]};
        step = 1'b1;
      end
      MODE_ROL: begin
        q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        step = 1'b1;
      end
      MODE_ROR: begin
        q_d  = {q_q[0], q_q[WIDTH-1:1]};
        step = 1'b1;
      end
      default: ;
    endcase
    // Count saturates at WIDTH while q keeps moving.
    if (step && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    done_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RST_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (rst) begin
      q_q    <= RST_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (bus.en) begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.cnt  = cnt_q;
  assign bus.done = done_q;
  assign bus.sout = ((mode == MODE_SHL) || (mode == MODE_ROL)) ? q_q[WIDTH-1] : q_q[0];

`ifdef SHIFT_REG_PARITY_EN
  assign bus.parity = ^q_q;
`endif
endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench for shift_reg_universal (WIDTH=8, RST_VAL=0) against an arithmetic model.
module tb_shift_reg_universal;
  logic clk;
  logic rst_n;
  logic rst;
  int   tests;
  int   fails;

  int   m_q, m_cnt, m_done;
  logic obs_sout, exp_sout;

  shift_reg_universal_if #(.WIDTH(8)) bus ();

  shift_reg_universal #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive at negedge, capture sout before the edge, advance model, settle.
  task automatic step(input logic en, input logic r, input int mode, input int d, input logic sin);
    @(negedge clk);
    bus.en   = en;
    rst      = r;
    bus.mode = 3'(mode);
    bus.d    = 8'(d);
    bus.sin  = sin;
    #1;
    obs_sout = bus.sout;
    exp_sout = (mode == 2 || mode == 4) ? logic'((m_q >> 7) & 1) : logic'(m_q & 1);
    @(posedge clk);
    if (r) begin
      m_q = 0; m_cnt = 0; m_done = 0;
    end else if (en) begin
      case (mode)
        1: begin m_q = d & 255; m_cnt = 0; end
        2: m_q = ((m_q << 1) | int'(sin)) & 255;
        3: m_q = (int'(sin) << 7) | (m_q >> 1);
        4: m_q = ((m_q << 1) | (m_q >> 7)) & 255;
        5: m_q = ((m_q & 1) << 7) | (m_q >> 1);
        default: ;
      endcase
      if (mode >= 2 && mode <= 5 && m_cnt < 8) m_cnt = m_cnt + 1;
      m_done = (m_cnt == 8) ? 1 : 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst = 1'b0;
    bus.en = 1'b0; bus.mode = 3'b000; bus.d = '0; bus.sin = 1'b0;
    m_q = 0; m_cnt = 0; m_done = 0;
    #12;
    tests++;
    if (bus.q !== 8'h00 || bus.cnt !== 4'd0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: q=%h cnt=%0d done=%b required q=00 cnt=0 done=0", bus.q, bus.cnt, bus.done);
    end
    @(negedge clk); rst_n = 1'b1;
    step(1, 0, 1, 8'hA5, 0);
    tests++;
    if (bus.q !== 8'hA5) begin
      fails++; $display("FAIL async_pre_load: q=%h required A5", bus.q);
    end
    #2 rst_n = 1'b0;
    #1;
    m_q = 0; m_cnt = 0; m_done = 0;
    tests++;
    if (bus.q !== 8'h00 || bus.cnt !== 4'd0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: q=%h cnt=%0d done=%b required q=00 cnt=0 done=0", bus.q, bus.cnt, bus.done);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load_hold();
    step(1, 0, 1, 8'hA5, 0);
    tests++;
    if (bus.q !== 8'hA5 || bus.cnt !== 4'd0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL load: q=%h cnt=%0d done=%b required q=A5 cnt=0 done=0", bus.q, bus.cnt, bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2, 0, 1);
      tests++;
      if (bus.q !== 8'hA5 || bus.cnt !== 4'd0) begin
        fails++; $display("FAIL en_hold[%0d]: q=%h cnt=%0d required q=A5 cnt=0", i, bus.q, bus.cnt);
      end
    end
  endtask

  task automatic test_shift_left();
    logic [7:0] exp_q [3];
    logic       exp_so [3];
    exp_q[0] = 8'h4B; exp_q[1] = 8'h97; exp_q[2] = 8'h2F;
    exp_so[0] = 1'b1; exp_so[1] = 1'b0; exp_so[2] = 1'b1;
    step(1, 0, 1, 8'hA5, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 2, 0, 1);
      tests++;
      if (obs_sout !== exp_so[i]) begin
        fails++; $display("FAIL shl_sout[%0d]: sout=%b required %b", i, obs_sout, exp_so[i]);
      end
      tests++;
      if (bus.q !== exp_q[i] || bus.cnt !== 4'(i + 1) || bus.done !== 1'b0) begin
        fails++;
        $display("FAIL shl[%0d]: q=%h cnt=%0d done=%b required q=%h cnt=%0d done=0", i, bus.q, bus.cnt, bus.done, exp_q[i], i + 1);
      end
    end
  endtask

  task automatic test_rotate_right();
    step(1, 0, 1, 8'hA5, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 5, 0, 0);
    tests++;
    if (bus.q !== 8'hA5 || bus.cnt !== 4'd8 || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL ror8: q=%h cnt=%0d done=%b required q=A5 cnt=8 done=1", bus.q, bus.cnt, bus.done);
    end
    step(1, 0, 5, 0, 0);
    tests++;
    if (bus.q !== 8'hD2 || bus.cnt !== 4'd8 || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL ror9_saturate: q=%h cnt=%0d done=%b required q=D2 cnt=8 done=1", bus.q, bus.cnt, bus.done);
    end
  endtask

  task automatic test_sync_clear();
    step(1, 1, 1, 8'hFF, 0);
    tests++;
    if (bus.q !== 8'h00 || bus.cnt !== 4'd0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL sync_clear: q=%h cnt=%0d done=%b required q=00 cnt=0 done=0", bus.q, bus.cnt, bus.done);
    end
    step(1, 0, 1, 8'hFF, 0);
    tests++;
    if (bus.q !== 8'hFF) begin
      fails++; $display("FAIL reload_after_clear: q=%h required FF", bus.q);
    end
  endtask

`ifdef SHIFT_REG_PARITY_EN
  task automatic test_parity();
    step(1, 0, 1, 8'hA5, 0);
    tests++;
    if (bus.parity !== 1'b0) begin
      fails++; $display("FAIL parity_A5: parity=%b required 0", bus.parity);
    end
    step(1, 0, 1, 8'hA4, 0);
    tests++;
    if (bus.parity !== 1'b1) begin
      fails++; $display("FAIL parity_A4: parity=%b required 1", bus.parity);
    end
  endtask
`endif

  task automatic test_random();
    int mode;
    logic en, r;
    for (int i = 0; i < 400; i++) begin
      mode = int'($urandom_range(0, 7));
      en   = ($urandom_range(0, 9) != 0);
      r    = ($urandom_range(0, 39) == 0);
      step(en, r, mode, int'($urandom_range(0, 255)), logic'($urandom_range(0, 1)));
      tests++;
      if (obs_sout !== exp_sout) begin
        fails++; $display("FAIL rand_sout[%0d]: sout=%b required %b", i, obs_sout, exp_sout);
      end
      tests++;
      if (bus.q !== 8'(m_q) || bus.cnt !== 4'(m_cnt) || bus.done !== logic'(m_done)) begin
        fails++;
        $display("FAIL rand_state[%0d]: q=%h cnt=%0d done=%b required q=%h cnt=%0d done=%0d",
                 i, bus.q, bus.cnt, bus.done, m_q[7:0], m_cnt, m_done);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_load_hold();
    test_shift_left();
    test_rotate_right();
    test_sync_clear();
`ifdef SHIFT_REG_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
